inst_encoder: RTL and testbench
===============================

# inst_encoder

Instruction encoder and program-loader writer: accepts decoded instruction fields (opcode, register indices, funct3/funct7, full 32-bit immediate) over a valid/ready handshake, packs them into RV32I machine words, buffers them in a small FIFO and writes them sequentially into instruction memory. It is the inverse of the instruction decoder. It is used by the test harness and the boot/self-test path to build programs in imem without an external assembler.

## Interface
- FIFO_DEPTH, 4, encoded-word buffer depth (power of 2, ≥2)
- ADDR_W, 10, imem word-address width
- BASE_ADDR, 0, word address of the first write after reset/restart
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- restart  in  1  pulse: flush FIFO, address ← BASE_ADDR, count ← 0
- in_valid / in_ready  in / out  1 / 1  field handshake
- in_op  in  7  opcode
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_funct3 / in_funct7  in  3 / 7  function fields
- in_imm  in  32  immediate as the decoder outputs it: U-type pre-shifted; B/J are byte offsets
- mem_we  out  1  write request
- mem_ready  in  1  imem accepts the write this cycle
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded word
- count  out  ADDR_W+1  words written since reset/restart
- busy  out  1  FIFO non-empty
- err_illegal, err_range  out  1 each  sticky error flags
- clr_err  in  1  clears sticky flags

## Operation
- Encode is combinational at the input. Formats:
  - R3: {f7,rs2,rs1,f3,rd,op}
  - LD/JALR/IMM: {imm[11:0],rs1,f3,rd,op}
  - IMM with f3=001/101: {f7,imm[4:0],rs1,f3,rd,op}
  - ST: {imm[11:5],rs2,rs1,f3,imm[4:0],op}
  - BR: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}
  - LUI/AUIPC: {imm[31:12],rd,op}
  - JAL: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}
- Unknown opcode: accepted (handshake completes), not pushed, err_illegal set.
- Writer FSM:
  - IDLE: FIFO empty, mem_we=0.
  - WRITE: mem_we=1, head word on mem_wdata.
  - Transfer when mem_we&&mem_ready: pop, mem_addr+1, count+1. Return to IDLE when the FIFO drains.
  - mem_addr/mem_wdata held stable while mem_we=1 and mem_ready=0.
- mem_addr wraps from 2^ADDR_W−1 to 0. count saturates at 2^(ADDR_W+1)−1.
- restart has priority over everything: the in-flight write is aborted (mem_we=0 next cycle), the FIFO is emptied, and a concurrent input handshake is discarded.
- Sticky errors: set on event, cleared by clr_err. A simultaneous new error wins over clr_err.

## Timing
- Reset values: in_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, busy=0, err_*=0.
- in_ready = !full. There is no same-cycle push/pop bypass when full.
- Latency: word accepted at cycle N → mem_we=1 with that word at N+1 (FIFO empty, IDLE).
- Throughput: 1 word/cycle with mem_ready held high.
- mem_wdata=0 whenever mem_we=0.

## Configuration
- ENC_RANGE_CHECK_EN defined — immediates that do not fit their field are dropped and set err_range. Fit rules:
  - I/S: signed 12-bit
  - B: signed 13-bit with bit0=0
  - J: signed 21-bit with bit0=0
  - U: low 12 bits zero
- ENC_RANGE_CHECK_EN undefined — out-of-range bits are silently truncated and err_range is tied 0.

## Structure
- Package inst_enc_pkg:
  - opcode and funct3 constants, aligned with the shared instruction definitions
  - fmt_t enum (R, I, I_SH, S, B, U, J, ILL)
  - writer state enum
  - pure function encode_fields()
- Sub-module sync_fifo (params WIDTH=32, DEPTH=FIFO_DEPTH), with pointer-based full/empty.

## Test plan
- addi x1,x0,5 (op=0010011, rd=1, imm=5) → mem_wdata=0x00500093 at mem_addr=0, one cycle after handshake.
- sw x2,8(x1) then beq x1,x2,−4 (imm=0xFFFFFFFC) → 0x0020A423 at addr 0 and 0xFE208EE3 at addr 1; count=2.
- lui x5 with imm=0x12345000, then jal x1 with imm=0x800 → 0x123452B7, 0x001000EF.
- mem_ready=0, push 4 words (depth 4) → in_ready=0 after the 4th, mem_addr/mem_wdata stable. Release mem_ready → 4 writes on consecutive cycles, addresses 0..3.
- in_op=0x7F → no write, err_illegal=1. Assert clr_err together with a second illegal opcode → err_illegal stays 1.
- addi imm=4096 → with ENC_RANGE_CHECK_EN: no write, err_range=1. Without: writes 0x00000093. restart mid-backpressure → mem_we=0, busy=0, next write lands at BASE_ADDR.

Source files
------------

// File: rtl/inst_enc_pkg.sv
// Opcode/funct3 constants, field and format types, and the pure encode/fit helpers.
// Range fitting is only consulted when ENC_RANGE_CHECK_EN is defined.
package inst_enc_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_I_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILL
    } fmt_t;

    localparam logic [0:0] WR_IDLE  = 1'b0;
    localparam logic [0:0] WR_WRITE = 1'b1;

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } fields_t;

    function automatic fmt_t get_fmt(input logic [6:0] op, input logic [2:0] f3);
        fmt_t fmt;
        case (op)
            OP_REG:            fmt = FMT_R;
            OP_LOAD, OP_JALR:  fmt = FMT_I;
            OP_IMM:            fmt = (f3 == F3_SLL || f3 == F3_SRX) ? FMT_I_SH : FMT_I;
            OP_STORE:          fmt = FMT_S;
            OP_BRANCH:         fmt = FMT_B;
            OP_LUI, OP_AUIPC:  fmt = FMT_U;
            OP_JAL:            fmt = FMT_J;
            default:           fmt = FMT_ILL;
        endcase
        return fmt;
    endfunction

    function automatic logic [31:0] encode_fields(input fmt_t fmt, input fields_t f);
        logic [31:0] w;
        case (fmt)
            FMT_R:    w = {f.f7, f.rs2, f.rs1, f.f3, f.rd, f.op};
            FMT_I:    w = {f.imm[11:0], f.rs1, f.f3, f.rd, f.op};
            FMT_I_SH: w = {f.f7, f.imm[4:0], f.rs1, f.f3, f.rd, f.op};
            FMT_S:    w = {f.imm[11:5], f.rs2, f.rs1, f.f3, f.imm[4:0], f.op};
            FMT_B:    w = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.f3, f.imm[4:1], f.imm[11], f.op};
            FMT_U:    w = {f.imm[31:12], f.rd, f.op};
            FMT_J:    w = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.op};
            default:  w = 32'd0;
        endcase
        return w;
    endfunction

    // Sign-extension test: every bit above the field's sign bit must copy it.
    function automatic logic imm_fits(input fmt_t fmt, input logic [31:0] imm);
        logic ok;
        case (fmt)
            FMT_I, FMT_I_SH, FMT_S: ok = (&imm[31:11]) || !(|imm[31:11]);
            FMT_B:                  ok = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
            FMT_J:                  ok = ((&imm[31:20]) || !(|imm[31:20])) && !imm[0];
            FMT_U:                  ok = (imm[11:0] == 12'd0);
            default:                ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: generic single-clock FIFO with wrap-bit pointers.
// Latency: a pushed word is visible on pop_dat the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; flush empties it.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded RV32I fields into machine words and writes them into imem; option ENC_RANGE_CHECK_EN.
// Latency: a word accepted at cycle N drives mem_we/mem_wdata at N+1 when the FIFO was empty.
// Backpressure: in_ready = !full (no bypass); writes hold address/data while mem_ready is low.
module inst_encoder
    import inst_enc_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 10,
    parameter int BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              err_illegal,
    output logic              err_range,
    input  logic              clr_err
);
    localparam int                LVL_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   CNT_MAX = '1;

    fields_t          fld;
    fmt_t             fmt;
    logic [31:0]      enc_word;
    logic             fits, accept, push, ill_evt;
    logic             fifo_full, fifo_empty, xfer;
    logic [31:0]      head;
    logic [LVL_W-1:0] level;
    logic [0:0]       state, state_nxt;

    assign fld = '{op: in_op, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                   f3: in_funct3, f7: in_funct7, imm: in_imm};
    assign fmt      = get_fmt(in_op, in_funct3);
    assign enc_word = encode_fields(fmt, fld);

`ifdef ENC_RANGE_CHECK_EN
    logic rng_evt;
    assign fits    = imm_fits(fmt, in_imm);
    assign rng_evt = accept && (fmt != FMT_ILL) && !fits;
`else
    assign fits = 1'b1;
`endif

    // restart swallows any handshake landing in the same cycle.
    assign in_ready = !fifo_full;
    assign accept   = in_valid && in_ready && !restart;
    assign push     = accept && (fmt != FMT_ILL) && fits;
    assign ill_evt  = accept && (fmt == FMT_ILL);

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (restart),
        .push     (push),
        .push_dat (enc_word),
        .pop      (xfer),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (level)
    );

    assign mem_we    = (state == WR_WRITE) && !restart;
    assign xfer      = mem_we && mem_ready;
    assign mem_wdata = mem_we ? head : 32'd0;
    assign busy      = !fifo_empty;

    always_comb begin
        state_nxt = state;
        case (state)
            WR_IDLE:  if (push) state_nxt = WR_WRITE;
            WR_WRITE: if (xfer && level == LVL_W'(1) && !push) state_nxt = WR_IDLE;
            default:  state_nxt = WR_IDLE;
        endcase
        if (restart) state_nxt = WR_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= WR_IDLE;
            mem_addr <= BASE;
            count    <= '0;
        end else begin
            state <= state_nxt;
            if (restart) begin
                mem_addr <= BASE;
                count    <= '0;
            end else if (xfer) begin
                mem_addr <= mem_addr + ADDR_W'(1);
                if (count != CNT_MAX) count <= count + (ADDR_W+1)'(1);
            end
        end
    end

    // A fresh error event outranks a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       err_illegal <= 1'b0;
        else if (ill_evt) err_illegal <= 1'b1;
        else if (clr_err) err_illegal <= 1'b0;
    end

`ifdef ENC_RANGE_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       err_range <= 1'b0;
        else if (rng_evt) err_range <= 1'b1;
        else if (clr_err) err_range <= 1'b0;
    end
`else
    assign err_range = 1'b0;
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: queue-based reference model compared every cycle plus directed literal checks.
module tb_inst_encoder;
    localparam int DEPTH = 4;
    localparam int AW    = 3;
    localparam int BASE  = 0;
`ifdef ENC_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic          clk = 1'b0, rst_n = 1'b1, restart = 1'b0, clr_err = 1'b0;
    logic          in_valid = 1'b0, mem_ready = 1'b1;
    logic [6:0]    in_op = '0, in_funct7 = '0;
    logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]    in_funct3 = '0;
    logic [31:0]   in_imm = '0;
    logic          in_ready, mem_we, busy, err_illegal, err_range;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   count;

    int checks = 0, errors = 0, cyc = 0;
    bit [31:0] mq[$];
    int        maddr = BASE, mcnt = 0;
    bit        mill = 1'b0, mrng = 1'b0;
    int        waddr[$], wcyc[$];
    bit [31:0] wdat[$];

    inst_encoder #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .count(count), .busy(busy),
        .err_illegal(err_illegal), .err_range(err_range), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired before test end");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Reference encoding from the instruction-format rules, using shifts and masks.
    function automatic void model_enc(input bit [6:0] op, input bit [4:0] rd, input bit [4:0] rs1,
                                      input bit [4:0] rs2, input bit [2:0] f3, input bit [6:0] f7,
                                      input bit [31:0] imm, output bit [31:0] w, output int kind);
        bit [31:0] o, d, a, b, f, g, base_i;
        int signed s;
        bit fits;
        o = op; d = rd; a = rs1; b = rs2; f = f3; g = f7; s = imm;
        base_i = (a << 15) | (f << 12) | (d << 7) | o;
        w = 0; kind = 0; fits = 1'b1;
        case (op)
            7'h33: w = (g << 25) | (b << 20) | base_i;
            7'h03, 7'h67: begin
                w = ((imm & 32'hFFF) << 20) | base_i;
                fits = (s >= -2048) && (s <= 2047);
            end
            7'h13: begin
                if (f3 == 3'd1 || f3 == 3'd5) w = (g << 25) | ((imm & 32'd31) << 20) | base_i;
                else                          w = ((imm & 32'hFFF) << 20) | base_i;
                fits = (s >= -2048) && (s <= 2047);
            end
            7'h23: begin
                w = (((imm >> 5) & 32'h7F) << 25) | (b << 20) | (a << 15) | (f << 12)
                    | ((imm & 32'd31) << 7) | o;
                fits = (s >= -2048) && (s <= 2047);
            end
            7'h63: begin
                w = (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (b << 20)
                    | (a << 15) | (f << 12) | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'd1) << 7) | o;
                fits = (s >= -4096) && (s <= 4095) && ((imm & 32'd1) == 0);
            end
            7'h37, 7'h17: begin
                w = (imm & 32'hFFFFF000) | (d << 7) | o;
                fits = ((imm & 32'hFFF) == 0);
            end
            7'h6F: begin
                w = (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                    | (((imm >> 11) & 32'd1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (d << 7) | o;
                fits = (s >= -1048576) && (s <= 1048575) && ((imm & 32'd1) == 0);
            end
            default: kind = 1;
        endcase
        if (kind == 0 && !fits && RC) kind = 2;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit we, rdy, ie, re;
        bit [31:0] w;
        int k;
        if (!rst_n) begin
            mq.delete(); maddr = BASE; mcnt = 0; mill = 1'b0; mrng = 1'b0;
        end else begin
            rdy = mq.size() < DEPTH;
            we  = (mq.size() != 0) && !restart;
            ie = 1'b0; re = 1'b0;
            if (restart) begin
                mq.delete(); maddr = BASE; mcnt = 0;
            end else begin
                if (we && mem_ready) begin
                    mq.delete(0);
                    maddr = (maddr + 1) % (1 << AW);
                    if (mcnt < (1 << (AW + 1)) - 1) mcnt++;
                end
                if (in_valid && rdy) begin
                    model_enc(in_op, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, w, k);
                    if (k == 0)      mq.push_back(w);
                    else if (k == 1) ie = 1'b1;
                    else             re = 1'b1;
                end
            end
            mill = ie ? 1'b1 : (clr_err ? 1'b0 : mill);
            mrng = re ? 1'b1 : (clr_err ? 1'b0 : mrng);
        end
    end

    always @(negedge clk) begin
        bit ewe;
        ewe = (mq.size() != 0) && !restart;
        chk("mem_we",      mem_we,      ewe);
        chk("mem_addr",    mem_addr,    maddr);
        chk("mem_wdata",   mem_wdata,   ewe ? mq[0] : 32'd0);
        chk("in_ready",    in_ready,    mq.size() < DEPTH);
        chk("busy",        busy,        mq.size() != 0);
        chk("count",       count,       mcnt);
        chk("err_illegal", err_illegal, mill);
        chk("err_range",   err_range,   mrng);
        if (mem_we && mem_ready) begin
            waddr.push_back(int'(mem_addr)); wdat.push_back(mem_wdata); wcyc.push_back(cyc);
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input bit [6:0] op, input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2,
                        input bit [2:0] f3, input bit [6:0] f7, input bit [31:0] imm);
        bit hs;
        hs = 1'b0;
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk); hs = in_ready;
            tick();
        end
        if (!hs) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1; tick(); restart = 1'b0;
    endtask

    task automatic wait_log(input int n);
        for (int i = 0; i < 200 && wlog_size() < n; i++) tick();
        chk("wait_log", wlog_size() >= n, 32'd1);
    endtask

    function automatic int wlog_size();
        return waddr.size();
    endfunction

    task automatic clear_log();
        waddr.delete(); wdat.delete(); wcyc.delete();
    endtask

    initial begin
        int n;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 32'd1);
        chk("rst_mem_we", mem_we, 32'd0);
        chk("rst_mem_addr", mem_addr, BASE);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_count", count, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_errs", {err_illegal, err_range}, 32'd0);
        tick();

        // addi x1,x0,5: visible the cycle after the handshake
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        @(negedge clk);
        chk("addi_lat_we", mem_we, 32'd1);
        chk("addi_lat_data", mem_wdata, 32'h00500093);
        chk("addi_lat_addr", mem_addr, 32'd0);
        wait_log(1);
        chk("addi_data", wdat[0], 32'h00500093);

        // sw x2,8(x1); beq x1,x2,-4
        do_restart(); clear_log();
        send(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC);
        wait_log(2);
        chk("sw_data", wdat[0], 32'h0020A423);
        chk("sw_addr", waddr[0], 32'd0);
        chk("beq_data", wdat[1], 32'hFE208EE3);
        chk("beq_addr", waddr[1], 32'd1);
        tick(); tick();
        chk("sw_beq_count", count, 32'd2);

        // lui x5,0x12345; jal x1,+0x800
        do_restart(); clear_log();
        send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800);
        wait_log(2);
        chk("lui_data", wdat[0], 32'h123452B7);
        chk("jal_data", wdat[1], 32'h001000EF);

        // fill FIFO under backpressure, then release
        do_restart(); clear_log();
        mem_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(7'h13, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i));
        @(negedge clk);
        chk("full_in_ready", in_ready, 32'd0);
        chk("bp_addr", mem_addr, 32'd0);
        chk("bp_data", mem_wdata, 32'h00100093);
        tick(); tick(); tick();
        @(negedge clk);
        chk("bp_addr_hold", mem_addr, 32'd0);
        chk("bp_data_hold", mem_wdata, 32'h00100093);
        tick();
        mem_ready = 1'b1;
        wait_log(4);
        for (int i = 0; i < 4; i++) begin
            chk("drain_addr", waddr[i], 32'(i));
            chk("drain_data", wdat[i], ((i + 1) << 20) | ((i + 1) << 7) | 32'h13);
            chk("drain_cycle", wcyc[i] - wcyc[0], 32'(i));
        end

        // illegal opcode, then clear racing a second illegal
        tick();
        n = wlog_size();
        send(7'h7F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        tick();
        @(negedge clk);
        chk("ill_flag", err_illegal, 32'd1);
        chk("ill_nowrite", wlog_size(), 32'(n));
        chk("ill_busy", busy, 32'd0);
        tick();
        clr_err = 1'b1;
        send(7'h7F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        clr_err = 1'b0;
        @(negedge clk);
        chk("ill_wins_clr", err_illegal, 32'd1);
        tick();
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        @(negedge clk);
        chk("ill_cleared", err_illegal, 32'd0);
        tick();

        // addi imm=4096 does not fit 12 bits
        n = wlog_size();
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096);
`ifdef ENC_RANGE_CHECK_EN
        tick(); tick();
        @(negedge clk);
        chk("rng_flag", err_range, 32'd1);
        chk("rng_nowrite", wlog_size(), 32'(n));
        tick();
        clr_err = 1'b1; tick(); clr_err = 1'b0;
`else
        wait_log(n + 1);
        chk("trunc_data", wdat[n], 32'h00000093);
        chk("trunc_no_rng", err_range, 32'd0);
`endif

        // restart while stalled, with a concurrent handshake that must be dropped
        do_restart(); clear_log();
        mem_ready = 1'b0;
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        send(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        in_op = 7'h13; in_rd = 5'd7; in_imm = 32'd7; in_valid = 1'b1; restart = 1'b1;
        tick();
        in_valid = 1'b0; restart = 1'b0;
        @(negedge clk);
        chk("rst_mid_we", mem_we, 32'd0);
        chk("rst_mid_busy", busy, 32'd0);
        chk("rst_mid_count", count, 32'd0);
        tick();
        mem_ready = 1'b1;
        send(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        wait_log(1);
        tick(); tick();
        chk("after_rst_addr", waddr[0], BASE);
        chk("after_rst_data", wdat[0], 32'h00300193);
        chk("after_rst_nwr", wlog_size(), 32'd1);

        // address wrap and count saturation, back-to-back throughput
        do_restart(); clear_log();
        for (int i = 0; i < 17; i++) send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(i));
        wait_log(17);
        tick(); tick();
        chk("wrap_addr7", waddr[7], 32'd7);
        chk("wrap_addr8", waddr[8], 32'd0);
        chk("wrap_addr16", waddr[16], 32'd0);
        chk("thru_cycles", wcyc[16] - wcyc[0], 32'd16);
        chk("count_sat", count, 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
